hazard_controller: RTL
======================

Name: hazard_controller

Overview:
Pipeline sequencing controller for the 5-stage RV32I core.
- Keeps a scoreboard of destination registers in flight downstream of decode.
- Raises the stall and bubble controls that freeze fetch/decode and inject NOPs on read-after-write hazards.
- Squashes wrong-path instructions after a taken jump.
- Freezes the whole pipeline while data memory is busy.
- Sits beside the decode stage; drives its stall input and the NOP-insert on its output registers.

Parameters:
- DEPTH, 3, number of in-flight writer stages tracked (EX, MEM, WB).
- FLUSH_CYCLES, 2, cycles of squash after a taken jump.
- CNT_W, 16, width of the saturating stall-cycle performance counter.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  reset; asynchronous, active-low.
- dec_valid  in  1  decode stage holds a valid instruction.
- dec_rs1_idx  in  5  source register 1 of the decode instruction.
- dec_rs1_used  in  1  instruction reads rs1.
- dec_rs2_idx  in  5  source register 2 of the decode instruction.
- dec_rs2_used  in  1  instruction reads rs2.
- dec_rd_idx  in  5  destination register of the decode instruction.
- dec_reg_write  in  1  instruction writes rd.
- ex_jump_taken  in  1  jump/branch resolved taken in execute.
- mem_busy  in  1  data memory not ready; whole pipeline must hold.
- stall_fetch  out  1  hold PC and fetch register.
- stall_decode  out  1  hold decode output registers (drives decode stall).
- bubble_ex  out  1  load NOP (all enables FALSE) into decode output registers.
- flush  out  1  invalidate instructions in fetch and decode.
- state_dbg  out  2  current FSM state encoding.
- stall_count  out  CNT_W  saturating count of cycles with stall_decode or bubble_ex high.

Behaviour:
Clocking and reset:
- All state updates on the rising edge of clk.
- Outputs are combinational from registered state plus current inputs (same-cycle response).
- rst_n low clears immediately: all scoreboard entries invalid, state RUN, flush counter 0, stall_count 0.
- Reset mid-FLUSH or mid-MEM_WAIT abandons the operation with no residue.

Scoreboard:
- DEPTH entries of {valid, rd}. Entry 0 = EX.
- Advances each cycle unless mem_busy. Entry i takes entry i-1.
- Entry 0 takes {1, dec_rd_idx} when dec_valid && dec_reg_write && dec_rd_idx!=0 && no stall/bubble/flush. Otherwise it takes invalid.

Hazard:
- raw = dec_valid && ((dec_rs1_used && rs1!=0 && rs1 matches any valid entry) || (same for rs2)).
- x0 never hazards.

FSM states:
- RUN=0: no pipeline control active.
- RAW=1: hazard stall in progress.
- FLUSH=2: post-jump squash; counter is loaded on entry.
- MEM_WAIT=3: pipeline frozen; the state in force on entry is remembered.

Transitions, in priority order:
1. mem_busy: go to or stay in MEM_WAIT. On deassertion, return to the remembered state; the flush counter resumes where it stopped.
2. ex_jump_taken: go to FLUSH and load FLUSH_CYCLES. A jump already in FLUSH reloads the counter.
3. FLUSH: decrement the counter each cycle; go to RUN when it reaches 0.
4. raw: go to RAW. Leave RAW when raw clears, typically once the writer drains out of entry DEPTH-1.

Outputs per state:
- MEM_WAIT: stall_fetch=1, stall_decode=1, bubble_ex=0, flush=0.
- FLUSH: flush=1, bubble_ex=1, stall_fetch=0, stall_decode=0.
- RAW (also the cycle raw first asserts in RUN): stall_fetch=1, bubble_ex=1, stall_decode=0.
- RUN with no hazard: all controls 0.

Other rules:
- stall_count increments when stall_decode||bubble_ex and saturates at 2^CNT_W-1.
- Simultaneous jump and raw: flush wins; the hazarding instruction is on the wrong path.
- A jump arriving during mem_busy is ignored; the execute stage holds it until the freeze ends.

Decomposition:
Package pipeline_pkg holds:
- RegId (5 b) and Bool.
- HazardState enum {RUN, RAW, FLUSH, MEM_WAIT}.
- REG_ZERO constant.
- Default FLUSH_CYCLES value.

Sub-module hazard_scoreboard (DEPTH-entry shift register plus match logic) provides:
- Inputs: advance, insert_valid, insert_rd, rs1/rs2 query.
- Outputs: raw_hit.

Test Plan:
1. Reset with rst_n=0 while dec_valid=1 and rs1=5 -> all outputs 0, state_dbg=0. Release and issue rd=5 write, then rs1=5 read next cycle -> bubble_ex=1 and stall_fetch=1 for 3 cycles, then 0. stall_count=3.
2. Writer rd=0 followed by a reader of x0 -> no stall; stall_count stays 0.
3. ex_jump_taken pulse for 1 cycle -> flush=1 and bubble_ex=1 for exactly 2 cycles, state_dbg 2 then 0.
4. mem_busy=1 for 4 cycles during FLUSH with counter=1 -> stall_fetch/stall_decode high for 4 cycles, scoreboard frozen. Then 1 further flush cycle, then RUN.
5. ex_jump_taken and raw in the same cycle -> flush=1, stall_fetch=0, scoreboard entry 0 inserted invalid.
6. stall_count preloaded to 0xFFFE, then 3 stall cycles -> value holds at 0xFFFF.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types for the RV32I pipeline sequencing logic.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: register-index and boolean types, the hazard FSM state
// encoding (also exported on state_dbg), the x0 constant and the
// default squash length after a taken jump.
package pipeline_pkg;

    typedef logic [4:0] reg_id_t;
    typedef logic       bool_t;

    // Encoding is visible on state_dbg, so the values are fixed.
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_RAW      = 2'd1,
        ST_FLUSH    = 2'd2,
        ST_MEM_WAIT = 2'd3
    } hazard_state_t;

    localparam reg_id_t REG_ZERO         = 5'd0;
    localparam int      FLUSH_CYCLES_DEF = 2;

endpackage

// File: rtl/hazard_controller_if.sv
// Decode-side bundle between the pipeline and the hazard controller.
// Latency: n/a (wires only).
// Backpressure: n/a; the controls carried here are themselves the pipeline's stall signals.
//
// master: the pipeline (drives decode info, jump, mem_busy; receives controls).
// slave : the hazard controller.
interface hazard_controller_if
    import pipeline_pkg::*;
#(
    parameter int CNT_W = 16
) ();

    bool_t              dec_valid;
    reg_id_t            dec_rs1_idx;
    bool_t              dec_rs1_used;
    reg_id_t            dec_rs2_idx;
    bool_t              dec_rs2_used;
    reg_id_t            dec_rd_idx;
    bool_t              dec_reg_write;
    bool_t              ex_jump_taken;
    bool_t              mem_busy;

    bool_t              stall_fetch;
    bool_t              stall_decode;
    bool_t              bubble_ex;
    bool_t              flush;
    logic [1:0]         state_dbg;
    logic [CNT_W-1:0]   stall_count;

    modport master (
        output dec_valid, dec_rs1_idx, dec_rs1_used, dec_rs2_idx, dec_rs2_used,
               dec_rd_idx, dec_reg_write, ex_jump_taken, mem_busy,
        input  stall_fetch, stall_decode, bubble_ex, flush, state_dbg, stall_count
    );

    modport slave (
        input  dec_valid, dec_rs1_idx, dec_rs1_used, dec_rs2_idx, dec_rs2_used,
               dec_rd_idx, dec_reg_write, ex_jump_taken, mem_busy,
        output stall_fetch, stall_decode, bubble_ex, flush, state_dbg, stall_count
    );

endinterface

// File: rtl/hazard_scoreboard.sv
// In-flight destination-register tracker (entry 0 = EX) with RAW match.
// Latency: raw_hit_o is combinational; insertions become visible the cycle after.
// Backpressure: holds all entries while advance_i is low.
//
// Ports: clk/rst_n; advance_i, insert_valid_i, insert_rd_i (shift-in);
// rs1/rs2 index + used query (callers gate "used" with decode valid);
// raw_hit_o when any valid entry matches a used, non-x0 source.
module hazard_scoreboard
    import pipeline_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic    clk,
    input  logic    rst_n,
    input  bool_t   advance_i,
    input  bool_t   insert_valid_i,
    input  reg_id_t insert_rd_i,
    input  reg_id_t rs1_idx_i,
    input  bool_t   rs1_used_i,
    input  reg_id_t rs2_idx_i,
    input  bool_t   rs2_used_i,
    output bool_t   raw_hit_o
);

    logic [DEPTH-1:0] vld_q;
    reg_id_t          rd_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) rd_q[i] <= REG_ZERO;
        end else if (advance_i) begin
            vld_q[0] <= insert_valid_i;
            rd_q[0]  <= insert_rd_i;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
                rd_q[i]  <= rd_q[i-1];
            end
        end
    end

    // x0 is hard-wired, so a read of it can never depend on a writer.
    always_comb begin
        raw_hit_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] &&
                ((rs1_used_i && rs1_idx_i != REG_ZERO && rs1_idx_i == rd_q[i]) ||
                 (rs2_used_i && rs2_idx_i != REG_ZERO && rs2_idx_i == rd_q[i])))
                raw_hit_o = 1'b1;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencing: RAW stall/bubble, post-jump squash, memory freeze.
// Latency: controls respond in the same cycle as their inputs.
// Backpressure: mem_busy freezes scoreboard, FSM and flush counter in place.
//
// Ports: clk, rst_n (async, active-low) and a slave hazard_controller_if
// carrying decode info, ex_jump_taken, mem_busy in and stall_fetch,
// stall_decode, bubble_ex, flush, state_dbg, stall_count out.
module hazard_controller
    import pipeline_pkg::*;
#(
    parameter int DEPTH        = 3,
    parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
    parameter int CNT_W        = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    hazard_controller_if.slave  hz
);

    localparam int FC_W = $clog2(FLUSH_CYCLES + 1);
    // The jump cycle itself is the first squash cycle, so the counter
    // holds the squash cycles still owed after it.
    localparam logic [FC_W-1:0] FLUSH_RELOAD = FC_W'(FLUSH_CYCLES - 1);

    hazard_state_t    state_q, state_d, saved_q, saved_d, eff_state;
    logic [FC_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q;
    bool_t            raw_hit, squash, insert_valid;
    bool_t            stall_fetch, stall_decode, bubble_ex, flush;

    hazard_scoreboard #(.DEPTH(DEPTH)) u_scoreboard (
        .clk            (clk),
        .rst_n          (rst_n),
        .advance_i      (!hz.mem_busy),
        .insert_valid_i (insert_valid),
        .insert_rd_i    (hz.dec_rd_idx),
        .rs1_idx_i      (hz.dec_rs1_idx),
        .rs1_used_i     (hz.dec_valid && hz.dec_rs1_used),
        .rs2_idx_i      (hz.dec_rs2_idx),
        .rs2_used_i     (hz.dec_valid && hz.dec_rs2_used),
        .raw_hit_o      (raw_hit)
    );

    // The cycle mem_busy drops, behave as the state frozen on entry so
    // the pending squash resumes without an extra stall cycle.
    assign eff_state = (state_q == ST_MEM_WAIT) ? saved_q : state_q;

    // A taken jump outranks a RAW hazard: the hazarding instruction is
    // on the wrong path and is squashed anyway.
    assign squash = !hz.mem_busy && (hz.ex_jump_taken || eff_state == ST_FLUSH);

    assign stall_fetch  = hz.mem_busy || (!squash && raw_hit);
    assign stall_decode = hz.mem_busy;
    assign bubble_ex    = !hz.mem_busy && (squash || raw_hit);
    assign flush        = squash;

    assign insert_valid = hz.dec_valid && hz.dec_reg_write && hz.dec_rd_idx != REG_ZERO &&
                          !stall_decode && !bubble_ex && !flush;

    always_comb begin
        state_d     = state_q;
        saved_d     = saved_q;
        flush_cnt_d = flush_cnt_q;
        if (hz.mem_busy) begin
            // A jump seen here is ignored; execute re-presents it later.
            state_d = ST_MEM_WAIT;
            saved_d = eff_state;
        end else if (hz.ex_jump_taken) begin
            flush_cnt_d = FLUSH_RELOAD;
            state_d     = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
        end else if (eff_state == ST_FLUSH) begin
            flush_cnt_d = flush_cnt_q - FC_W'(1);
            state_d     = (flush_cnt_q == FC_W'(1)) ? ST_RUN : ST_FLUSH;
        end else if (raw_hit) begin
            state_d = ST_RAW;
        end else begin
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            saved_q     <= ST_RUN;
            flush_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            saved_q     <= saved_d;
            flush_cnt_q <= flush_cnt_d;
            if ((stall_decode || bubble_ex) && stall_cnt_q != {CNT_W{1'b1}})
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign hz.stall_fetch  = stall_fetch;
    assign hz.stall_decode = stall_decode;
    assign hz.bubble_ex    = bubble_ex;
    assign hz.flush        = flush;
    assign hz.state_dbg    = state_q;
    assign hz.stall_count  = stall_cnt_q;

endmodule
